// File: rtl/pzvip_tilelink_a_arbiter_if.sv
// TileLink A+D link bundle; LANES valid/ready pairs share one set of D payload wires.
// Latency: none, wires only.
// Backpressure: a_ready/d_ready per lane, driven by the slave/master side respectively.
interface pzvip_tilelink_a_arbiter_if #(
    parameter int LANES      = 1,
    parameter int SOURCE_W   = 4,
    parameter int SIZE_W     = 3,
    parameter int A_OTHERS_W = 100,
    parameter int D_OTHERS_W = 72
);
    // A channel, lane i at [i*W +: W]
    logic [LANES-1:0]            a_valid;
    logic [LANES-1:0]            a_ready;
    logic [LANES*3-1:0]          a_opcode;
    logic [LANES*SIZE_W-1:0]     a_size;
    logic [LANES*SOURCE_W-1:0]   a_source;
    logic [LANES*A_OTHERS_W-1:0] a_others;

    // D channel: per-lane handshake, broadcast payload
    logic [LANES-1:0]            d_valid;
    logic [LANES-1:0]            d_ready;
    logic [2:0]                  d_opcode;
    logic [SIZE_W-1:0]           d_size;
    logic [SOURCE_W-1:0]         d_source;
    logic [D_OTHERS_W-1:0]       d_others;

    // Requester side: issues A, consumes D
    modport master (
        output a_valid, a_opcode, a_size, a_source, a_others, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_others
    );

    // Responder side: consumes A, issues D
    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_others, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_others
    );
endinterface

// File: rtl/pzvip_tilelink_a_arbiter.sv
// N-to-1 round-robin TileLink A arbiter with burst locking; D responses routed back by upper source bits.
// Latency: 0 cycles on A and D (combinational mux/demux); d_route_error is registered, 1 cycle.
// Backpressure: s_a_ready passes only to the granted requester; s_d_ready follows the addressed m_d_ready.
module pzvip_tilelink_a_arbiter #(
    parameter int N          = 4,
    parameter int SOURCE_W   = 4,
    parameter int SIZE_W     = 3,
    parameter int DATA_BYTES = 8,
    parameter int A_OTHERS_W = 100,
    parameter int D_OTHERS_W = 72
) (
    input  logic                      clock,
    input  logic                      reset_n,
    pzvip_tilelink_a_arbiter_if.slave  m_if,
    pzvip_tilelink_a_arbiter_if.master s_if,
    output logic                      d_route_error
);

    localparam int IDX_W      = $clog2(N);
    localparam int BEAT_SHIFT = $clog2(DATA_BYTES);
    localparam int SRC_DW     = SOURCE_W + IDX_W;
    localparam int MAX_SIZE   = (1 << SIZE_W) - 1;
    localparam int MAX_EXP    = (MAX_SIZE > BEAT_SHIFT) ? (MAX_SIZE - BEAT_SHIFT) : 0;
    localparam int CNT_W      = MAX_EXP + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // N widened by one bit so index comparisons stay meaningful when N is a power of two
    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // Data-carrying opcodes (PutFull, PutPartial, Arithmetic, Logical) span size/bus-width beats
    function automatic cnt_t beats_of(input logic [2:0] opcode, input logic [SIZE_W-1:0] size);
        cnt_t b;
        b = cnt_t'(1);
        if ((opcode < 3'd4) && (int'(size) > BEAT_SHIFT)) begin
            b = cnt_t'(1) << (int'(size) - BEAT_SHIFT);
        end
        return b;
    endfunction

    // Round-robin successor, wrapping at N
    function automatic idx_t next_idx(input idx_t g);
        idx_t n;
        if ({1'b0, g} == (N_EXT - 1'b1)) begin
            n = '0;
        end else begin
            n = g + 1'b1;
        end
        return n;
    endfunction

    state_t             state_q, state_d;
    idx_t               rr_ptr_q, rr_ptr_d;
    idx_t               grant_q, grant_d;
    cnt_t               beat_cnt_q, beat_cnt_d;
    logic               route_err_q, route_err_d;

    idx_t               arb_grant;
    logic               arb_found;
    logic [IDX_W:0]     rr_sum;
    idx_t               eff_grant;
    logic               sel_valid;
    logic [2:0]         sel_opcode;
    logic [SIZE_W-1:0]  sel_size;
    logic [SOURCE_W-1:0] sel_source;
    logic [A_OTHERS_W-1:0] sel_others;
    cnt_t               sel_beats;
    logic               s_a_valid_w;
    logic               a_hs;
    logic [N-1:0]       a_ready_vec;

    idx_t               d_idx;
    logic [N-1:0]       d_valid_vec;
    logic               d_ready_w;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        arb_grant = rr_ptr_q;
        arb_found = 1'b0;
        rr_sum    = '0;
        for (int i = 0; i < N; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (rr_sum >= N_EXT) begin
                rr_sum = rr_sum - N_EXT;
            end
            if (!arb_found && m_if.a_valid[rr_sum[IDX_W-1:0]]) begin
                arb_grant = rr_sum[IDX_W-1:0];
                arb_found = 1'b1;
            end
        end
    end

    // Once a message is stalled or mid-burst, the latched grant overrides fresh arbitration
    assign eff_grant = (state_q == ST_IDLE) ? arb_grant : grant_q;

    // Payload mux for the effective grant
    always_comb begin
        sel_opcode = '0;
        sel_size   = '0;
        sel_source = '0;
        sel_others = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_t'(i) == eff_grant) begin
                sel_opcode = m_if.a_opcode[i*3 +: 3];
                sel_size   = m_if.a_size[i*SIZE_W +: SIZE_W];
                sel_source = m_if.a_source[i*SOURCE_W +: SOURCE_W];
                sel_others = m_if.a_others[i*A_OTHERS_W +: A_OTHERS_W];
            end
        end
    end

    assign sel_valid   = (state_q == ST_IDLE) ? (|m_if.a_valid) : m_if.a_valid[grant_q];
    assign s_a_valid_w = reset_n & sel_valid;
    assign a_hs        = s_a_valid_w & s_if.a_ready;
    assign sel_beats   = beats_of(sel_opcode, sel_size);

    // Ready goes only to the granted requester; in IDLE it also needs its own valid
    always_comb begin
        a_ready_vec = '0;
        for (int i = 0; i < N; i++) begin
            a_ready_vec[i] = reset_n & s_if.a_ready & (idx_t'(i) == eff_grant)
                           & ((state_q != ST_IDLE) | m_if.a_valid[i]);
        end
    end

    assign m_if.a_ready  = a_ready_vec;
    assign s_if.a_valid  = s_a_valid_w;
    assign s_if.a_opcode = sel_opcode;
    assign s_if.a_size   = sel_size;
    assign s_if.a_source = {eff_grant, sel_source};
    assign s_if.a_others = sel_others;

    // Arbitration state: hold on stall, lock for multi-beat messages, advance rr_ptr on completion
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (a_hs) begin
                    if (sel_beats == cnt_t'(1)) begin
                        rr_ptr_d = next_idx(eff_grant);
                        state_d  = ST_IDLE;
                    end else begin
                        beat_cnt_d = sel_beats - 1'b1;
                        grant_d    = eff_grant;
                        state_d    = ST_BURST;
                    end
                end else if (s_a_valid_w) begin
                    grant_d = eff_grant;
                    state_d = ST_HOLD;
                end
            end
            ST_BURST: begin
                if (a_hs) begin
                    if (beat_cnt_q == cnt_t'(1)) begin
                        rr_ptr_d = next_idx(grant_q);
                        state_d  = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // D demux by the requester index in the top source bits; unknown indices are sunk and flagged
    always_comb begin
        d_idx       = s_if.d_source[SRC_DW-1 -: IDX_W];
        d_valid_vec = '0;
        d_ready_w   = 1'b1;
        route_err_d = 1'b0;
        if ({1'b0, d_idx} < N_EXT) begin
            d_valid_vec[d_idx] = s_if.d_valid;
            d_ready_w          = m_if.d_ready[d_idx];
        end else begin
            route_err_d = s_if.d_valid;
        end
    end

    assign m_if.d_valid  = d_valid_vec;
    assign s_if.d_ready  = d_ready_w;
    assign m_if.d_opcode = s_if.d_opcode;
    assign m_if.d_size   = s_if.d_size;
    assign m_if.d_source = s_if.d_source[SOURCE_W-1:0];
    assign m_if.d_others = s_if.d_others;
    assign d_route_error = route_err_q;

    // State registers; reset abandons any burst in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            route_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            route_err_q <= route_err_d;
        end
    end

endmodule

// File: tb/tb_pzvip_tilelink_a_arbiter.sv
// Directed bench for the A arbiter: N=4 instance for arbitration/locking/D routing, N=3 for bad-index drops.
// Latency: checks combinational outputs at the falling edge, registered ones one cycle on.
// Backpressure: exercised through s_a_ready stalls and m_d_ready holds.
module tb_pzvip_tilelink_a_arbiter;

    logic clock = 1'b0;
    logic reset_n;
    logic err4, err3;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    pzvip_tilelink_a_arbiter_if #(.LANES(4), .SOURCE_W(4)) up4 ();
    pzvip_tilelink_a_arbiter_if #(.LANES(1), .SOURCE_W(6)) dn4 ();
    pzvip_tilelink_a_arbiter_if #(.LANES(3), .SOURCE_W(4)) up3 ();
    pzvip_tilelink_a_arbiter_if #(.LANES(1), .SOURCE_W(6)) dn3 ();

    pzvip_tilelink_a_arbiter #(.N(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .m_if(up4), .s_if(dn4), .d_route_error(err4)
    );

    pzvip_tilelink_a_arbiter #(.N(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .m_if(up3), .s_if(dn3), .d_route_error(err3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] sz);
        up4.a_opcode[i*3 +: 3] = op;
        up4.a_size[i*3 +: 3]   = sz;
    endtask

    logic [5:0]  exp_src [5] = '{6'h03, 6'h17, 6'h2B, 6'h3E, 6'h03};
    logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [99:0] exp_oth1 = {36'h0, 64'hA0A0_0000_0000_0001};

    initial begin
        reset_n = 1'b0;
        up4.a_valid = '0; up4.a_opcode = '0; up4.a_size = '0; up4.d_ready = '0;
        up4.a_source = {4'hE, 4'hB, 4'h7, 4'h3};
        for (int i = 0; i < 4; i++) up4.a_others[i*100 +: 100] = {36'h0, 64'hA0A0_0000_0000_0000 | 64'(i)};
        dn4.a_ready = 1'b0; dn4.d_valid = 1'b0; dn4.d_opcode = '0; dn4.d_size = '0;
        dn4.d_source = '0; dn4.d_others = '0;
        up3.a_valid = '0; up3.a_opcode = '0; up3.a_size = '0; up3.a_source = '0;
        up3.a_others = '0; up3.d_ready = '0;
        dn3.a_ready = 1'b0; dn3.d_valid = 1'b0; dn3.d_opcode = '0; dn3.d_size = '0;
        dn3.d_source = '0; dn3.d_others = '0;

        // Reset: outputs held quiet even with all requesters valid
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd3);
        up4.a_valid = 4'b1111;
        dn4.a_ready = 1'b1;
        @(negedge clock);
        chk("rst_s_a_valid", dn4.a_valid, 1'b0);
        chk("rst_m_a_ready", up4.a_ready, 4'b0000);
        chk("rst_err4", err4, 1'b0);
        chk("rst_err3", err3, 1'b0);
        tick();
        reset_n = 1'b1;

        // Round robin over four Gets: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("rr_source", dn4.a_source, exp_src[k]);
            chk("rr_ready", up4.a_ready, exp_rdy[k]);
            chk("rr_valid", dn4.a_valid, 1'b1);
            tick();
        end

        // Requester 1 PutFull 32B (4 beats) locks out requester 2
        up4.a_valid = 4'b0110;
        set_req(1, 3'd0, 3'd5);
        set_req(2, 3'd4, 3'd3);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            chk("burst_source", dn4.a_source, 6'h17);
            chk("burst_ready", up4.a_ready, 4'b0010);
            tick();
        end
        @(negedge clock);
        chk("burst_others", 128'(exp_oth1), 128'(up4.a_others[199:100]));
        chk("after_burst_source", dn4.a_source, 6'h2B);
        chk("after_burst_ready", up4.a_ready, 4'b0100);
        tick();

        // Single Get from 3 brings rr_ptr back to 0
        up4.a_valid = 4'b1000;
        @(negedge clock);
        chk("solo3_source", dn4.a_source, 6'h3E);
        tick();

        // Stall requester 3 (1-beat PutPartial) for 3 cycles; requester 0 rises meanwhile
        set_req(3, 3'd1, 3'd3);
        dn4.a_ready = 1'b0;
        @(negedge clock);
        chk("stall0_source", dn4.a_source, 6'h3E);
        chk("stall0_ready", up4.a_ready, 4'b0000);
        tick();
        up4.a_valid = 4'b1001;
        for (int s = 1; s < 3; s++) begin
            @(negedge clock);
            chk("stall_source", dn4.a_source, 6'h3E);
            chk("stall_opcode", dn4.a_opcode, 3'd1);
            chk("stall_ready", up4.a_ready, 4'b0000);
            tick();
        end
        dn4.a_ready = 1'b1;
        @(negedge clock);
        chk("stall_release_source", dn4.a_source, 6'h3E);
        chk("stall_release_ready", up4.a_ready, 4'b1000);
        tick();
        @(negedge clock);
        chk("post_stall_source", dn4.a_source, 6'h03);
        chk("post_stall_ready", up4.a_ready, 4'b0001);
        tick();
        up4.a_valid = 4'b0000;

        // D routing to requester 2 with 2 cycles of backpressure
        dn4.d_valid = 1'b1; dn4.d_source = 6'h25; dn4.d_opcode = 3'd1;
        up4.d_ready = 4'b1011;
        for (int s = 0; s < 2; s++) begin
            @(negedge clock);
            chk("d_valid", up4.d_valid, 4'b0100);
            chk("d_source", up4.d_source, 4'h5);
            chk("d_opcode", up4.d_opcode, 3'd1);
            chk("d_ready_stall", dn4.d_ready, 1'b0);
            tick();
        end
        up4.d_ready = 4'b1111;
        @(negedge clock);
        chk("d_ready_go", dn4.d_ready, 1'b1);
        chk("d_valid_go", up4.d_valid, 4'b0100);
        tick();
        dn4.d_source = 6'h0A;
        @(negedge clock);
        chk("d_valid_idx0", up4.d_valid, 4'b0001);
        chk("d_source_idx0", up4.d_source, 4'hA);
        chk("err4_quiet", err4, 1'b0);
        tick();
        dn4.d_valid = 1'b0;

        // N=3: index 3 is dropped and flagged for one cycle
        dn3.d_valid = 1'b1; dn3.d_source = 6'h31;
        @(negedge clock);
        chk("bad_idx_ready", dn3.d_ready, 1'b1);
        chk("bad_idx_valid", up3.d_valid, 3'b000);
        chk("bad_idx_err_before", err3, 1'b0);
        tick();
        dn3.d_valid = 1'b0;
        @(negedge clock);
        chk("bad_idx_err_pulse", err3, 1'b1);
        tick();
        @(negedge clock);
        chk("bad_idx_err_clear", err3, 1'b0);
        tick();

        // Reset during beat 2 of a 4-beat Put from requester 2 (rr_ptr is 1 here)
        up4.a_valid = 4'b0100;
        set_req(2, 3'd0, 3'd5);
        @(negedge clock);
        chk("rb_beat1_source", dn4.a_source, 6'h2B);
        tick();
        @(negedge clock);
        chk("rb_beat2_ready", up4.a_ready, 4'b0100);
        reset_n = 1'b0;
        #1;
        chk("rb_rst_s_a_valid", dn4.a_valid, 1'b0);
        chk("rb_rst_m_a_ready", up4.a_ready, 4'b0000);
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd3);
        up4.a_valid = 4'b1111;
        reset_n = 1'b1;
        @(negedge clock);
        chk("rb_after_source", dn4.a_source, 6'h03);
        chk("rb_after_ready", up4.a_ready, 4'b0001);
        tick();
        @(negedge clock);
        chk("rb_second_source", dn4.a_source, 6'h17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
